// File: rtl/usb_wb_arbiter.sv
// rtl/usb_wb_arbiter.sv - two-master round-robin arbiter for the USB core CSR/EP-status bus
module usb_wb_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int TIMEOUT = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  input  logic          m0_cyc,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  input  logic          m1_cyc,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_we,
  output logic          s_cyc,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack,
  output logic          timeout_evt
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] wd_cnt_q, wd_cnt_d;

  logic own;
  logic own_cyc;
  logic tmo;

  assign own     = (state_q == OWN0) || (state_q == OWN1);
  assign own_cyc = (state_q == OWN1) ? m1_cyc : m0_cyc;
  // An abort takes precedence over the watchdog, and a slave ack beats it.
  assign tmo     = own && own_cyc && !s_ack && (wd_cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wd_cnt_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wd_cnt_d     = wd_cnt_q;
    case (state_q)
      IDLE: begin
        wd_cnt_d = 8'd0;
        if (m0_cyc && (!m1_cyc || last_grant_q)) begin
          state_d      = OWN0;
          last_grant_d = 1'b0;
        end else if (m1_cyc) begin
          state_d      = OWN1;
          last_grant_d = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (s_ack || !own_cyc || tmo) begin
          state_d = GAP;
        end else if (wd_cnt_q != 8'hFF) begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc       = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_we        = 1'b0;
    m0_rdata    = '0;
    m0_ack      = 1'b0;
    m0_err      = 1'b0;
    m1_rdata    = '0;
    m1_ack      = 1'b0;
    m1_err      = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      OWN0: begin
        s_cyc       = m0_cyc && !tmo;
        s_addr      = m0_addr;
        s_wdata     = m0_wdata;
        s_we        = m0_we;
        m0_rdata    = s_rdata;
        m0_ack      = s_ack;
        m0_err      = tmo;
        timeout_evt = tmo;
      end
      OWN1: begin
        s_cyc       = m1_cyc && !tmo;
        s_addr      = m1_addr;
        s_wdata     = m1_wdata;
        s_we        = m1_we;
        m1_rdata    = s_rdata;
        m1_ack      = s_ack;
        m1_err      = tmo;
        timeout_evt = tmo;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_wb_arbiter.sv
// tb/tb_usb_wb_arbiter.sv - scoreboard bench for usb_wb_arbiter
module tb_usb_wb_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TIMEOUT = 31;

  typedef struct {
    int          m;
    logic [15:0] rdata;
    bit          err;
    logic [11:0] addr;
    logic [15:0] wdata;
    bit          we;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, s_wdata, m0_rdata, m1_rdata, s_rdata;
  logic m0_we, m1_we, m0_cyc, m1_cyc, m0_ack, m1_ack, m0_err, m1_err;
  logic s_we, s_cyc, s_ack, timeout_evt;

  logic [AW-1:0] a_addr[2];
  logic [DW-1:0] a_wdata[2];
  bit            a_we[2];
  bit            mcyc[2];
  int            pend[2];
  bit            done[2];
  int            raise_cyc[2];
  int            err_cyc[2];
  int            n_ack[2];
  int            ack_dly;
  logic [15:0]   slv_rdata;
  int            scnt;
  int            cyc_n = 0;
  int            rise_cyc, ack_cyc, last_evt_cyc, last_space, shigh, n_evt;
  logic          s_cyc_prev = 1'b0;
  exp_t          sb[$];
  exp_t          e, dummy;
  int            n_checks = 0;
  int            n_errors = 0;

  assign m0_addr  = a_addr[0];
  assign m1_addr  = a_addr[1];
  assign m0_wdata = a_wdata[0];
  assign m1_wdata = a_wdata[1];
  assign m0_we    = a_we[0];
  assign m1_we    = a_we[1];
  assign m0_cyc   = mcyc[0];
  assign m1_cyc   = mcyc[1];
  assign s_rdata  = slv_rdata;

  usb_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_cyc(m0_cyc),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_cyc(m1_cyc),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_cyc(s_cyc),
    .s_rdata(s_rdata), .s_ack(s_ack), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave acks ack_dly cycles after s_cyc rises; ack never depends on s_cyc combinationally.
  always @(posedge clk or posedge rst) begin
    if (rst) scnt <= 0;
    else     scnt <= s_cyc ? scnt + 1 : 0;
  end
  always_comb s_ack = (scnt == ack_dly);

  task automatic check(input string tag, input longint obs, input longint exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (s_cyc && !s_cyc_prev) begin
        rise_cyc   = cyc_n;
        last_space = cyc_n - last_evt_cyc;
      end
      if (s_cyc) shigh++;
      if ((m0_ack | m0_err) || (m1_ack | m1_err)) begin
        int m;
        m = (m1_ack | m1_err) ? 1 : 0;
        check("evt_onehot", (m0_ack | m0_err) & (m1_ack | m1_err), 0);
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("owner", m, e.m);
          check("err", m ? m1_err : m0_err, e.err);
          check("ack", m ? m1_ack : m0_ack, !e.err);
          check("timeout_evt", timeout_evt, e.err);
          check("s_addr", s_addr, e.addr);
          check("s_wdata", s_wdata, e.wdata);
          check("s_we", s_we, e.we);
          check("other_rdata", m ? m0_rdata : m1_rdata, 0);
          if (e.err) check("s_cyc_in_err", s_cyc, 0);
          else       check("rdata", m ? m1_rdata : m0_rdata, e.rdata);
        end
        done[m] = 1'b1;
        last_evt_cyc = cyc_n;
        n_evt++;
        if (m ? m1_err : m0_err) err_cyc[m] = cyc_n;
        else begin
          ack_cyc = cyc_n;
          n_ack[m]++;
        end
      end else begin
        check("timeout_evt_quiet", timeout_evt, 0);
      end
    end
    s_cyc_prev = s_cyc;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (done[m]) begin
        mcyc[m] = 1'b0;
        done[m] = 1'b0;
      end else if (!mcyc[m] && pend[m] > 0) begin
        exp_t x;
        pend[m]--;
        mcyc[m]      = 1'b1;
        raise_cyc[m] = cyc_n;
        x.m = m; x.rdata = slv_rdata; x.err = (ack_dly > TIMEOUT - 1);
        x.addr = a_addr[m]; x.wdata = a_wdata[m]; x.we = a_we[m];
        sb.push_back(x);
      end
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || pend[0] != 0 || pend[1] != 0 || mcyc[0] || mcyc[1]) && k < budget) begin
      cycle();
      k++;
    end
    check("drain_budget", k < budget, 1);
    cycle();
    cycle();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_s_cyc"}, s_cyc, 0);
    check({tag, "_s_addr"}, s_addr, 0);
    check({tag, "_acks"}, {m0_ack, m1_ack}, 0);
    check({tag, "_errs"}, {m0_err, m1_err, timeout_evt}, 0);
    check({tag, "_rdata"}, {m0_rdata, m1_rdata}, 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_quiet("async_rst");
    sb.delete();
    pend = '{0, 0};
    mcyc = '{0, 0};
    done = '{0, 0};
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    a_addr = '{12'h0, 12'h0}; a_wdata = '{16'h0, 16'h0}; a_we = '{0, 0};
    mcyc = '{0, 0}; pend = '{0, 0}; done = '{0, 0};
    raise_cyc = '{0, 0}; err_cyc = '{0, 0}; n_ack = '{0, 0};
    ack_dly = 1000; slv_rdata = 16'h0;
    rise_cyc = 0; ack_cyc = 0; last_evt_cyc = 0; last_space = 0; shigh = 0; n_evt = 0;
    #1 check_quiet("reset");
    cycle(); cycle();
    rst = 1'b0;
    cycle(); cycle();

    // single m0 read
    ack_dly = 1; slv_rdata = 16'hA5C3; a_addr[0] = 12'h010;
    shigh = 0; pend[0] = 1;
    drain(50);
    check("t1_rise", rise_cyc, raise_cyc[0] + 1);
    check("t1_ack", ack_cyc, raise_cyc[0] + 2);
    check("t1_scyc_cycles", shigh, 2);

    // contention straight out of reset, 4 transactions
    do_reset();
    begin
      int base;
      base = n_evt;
      slv_rdata = 16'h5A5A; a_addr[0] = 12'h020; a_addr[1] = 12'h030;
      pend = '{2, 2};
      drain(100);
      check("t2_count", n_evt - base, 4);
      check("t2_spacing", last_space, 3);
    end

    // m1 write, slave acks 3 cycles after s_cyc
    begin
      int b0, b1;
      b0 = n_ack[0]; b1 = n_ack[1];
      ack_dly = 3; slv_rdata = 16'h0F0F;
      a_addr[1] = 12'h804; a_wdata[1] = 16'h1234; a_we[1] = 1'b1;
      pend[1] = 1;
      drain(50);
      check("t3_ack_lat", ack_cyc, rise_cyc + 3);
      check("t3_m1_acks", n_ack[1], b1 + 1);
      check("t3_m0_acks", n_ack[0], b0);
      a_we[1] = 1'b0; a_wdata[1] = 16'h0;
    end

    // watchdog on m0 with m1 waiting, then m1 also times out
    ack_dly = 1000; a_addr[0] = 12'h100; a_addr[1] = 12'h104;
    pend[0] = 1;
    cycle();
    pend[1] = 1;
    drain(200);
    check("t4_err0_cycle", err_cyc[0], raise_cyc[0] + TIMEOUT);
    check("t4_err1_cycle", err_cyc[1], err_cyc[0] + 3 + TIMEOUT - 1);
    check("t4_spacing", last_space, 3);

    // ack on the watchdog limit cycle, then one cycle too late
    ack_dly = TIMEOUT - 1; slv_rdata = 16'hBEEF; pend[0] = 1;
    drain(100);
    check("t5_ack_at_limit", ack_cyc, raise_cyc[0] + TIMEOUT);
    ack_dly = TIMEOUT; pend[0] = 1;
    drain(100);
    check("t5_err_past_limit", err_cyc[0], raise_cyc[0] + TIMEOUT);

    // abort: m0 drops cyc while waiting
    begin
      int base;
      base = n_evt;
      ack_dly = 1000; pend[0] = 1;
      repeat (6) cycle();
      mcyc[0] = 1'b0;
      dummy = sb.pop_back();
      #1 check("t6_scyc_abort", s_cyc, 0);
      repeat (40) cycle();
      check("t6_no_evt", n_evt, base);
    end

    // reset during OWN1, then contention goes to m0
    a_addr[1] = 12'h200; pend[1] = 1;
    repeat (4) cycle();
    #1 check("t7_owned", s_cyc, 1);
    do_reset();
    begin
      int base;
      base = n_evt;
      ack_dly = 1; slv_rdata = 16'h7777; a_addr[0] = 12'h300; a_addr[1] = 12'h310;
      pend = '{1, 1};
      drain(100);
      check("t7_count", n_evt - base, 2);
    end

    check("sb_final_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
